// File: rtl/wishbone_interconnect_n.sv
// -----------------------------------------------------------------------------
// wishbone_interconnect_n
//
// Single-master, N-slave Wishbone interconnect with registered responses.
// The top address byte selects the slave. Only one transaction is in flight
// at a time. Unmapped addresses, and slaves that stay silent for too long,
// are answered with a one-cycle bus error. Slave interrupt levels are masked,
// registered and OR-ed into a single master interrupt.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   i_m_*               master request: we/stb/cyc, sel[3:0], adr[31:0], dat[31:0]
//   o_m_dat/ack/err     registered master response (ack/err are 1-cycle pulses)
//   o_m_int             registered OR of enabled slave interrupts
//   o_s_we/stb/cyc      per-slave control, bit i drives slave i
//   o_s_sel             per-slave byte selects, slice [4i+3:4i]
//   o_s_adr, o_s_dat    {8'h00, adr[23:0]} and write data, 32 bits per slave
//   i_s_dat, i_s_ack    per-slave read data and ack
//   i_s_int, i_int_en   slave interrupt levels and enable mask
//   o_int_status        registered i_s_int & i_int_en
//   o_err_count         saturating count of error responses
// -----------------------------------------------------------------------------
module wishbone_interconnect_n #(
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_m_we,
    input  logic                     i_m_stb,
    input  logic                     i_m_cyc,
    input  logic [3:0]               i_m_sel,
    input  logic [31:0]              i_m_adr,
    input  logic [31:0]              i_m_dat,
    output logic [31:0]              o_m_dat,
    output logic                     o_m_ack,
    output logic                     o_m_err,
    output logic                     o_m_int,
    output logic [NUM_SLAVES-1:0]    o_s_we,
    output logic [NUM_SLAVES-1:0]    o_s_stb,
    output logic [NUM_SLAVES-1:0]    o_s_cyc,
    output logic [4*NUM_SLAVES-1:0]  o_s_sel,
    output logic [32*NUM_SLAVES-1:0] o_s_adr,
    output logic [32*NUM_SLAVES-1:0] o_s_dat,
    input  logic [32*NUM_SLAVES-1:0] i_s_dat,
    input  logic [NUM_SLAVES-1:0]    i_s_ack,
    input  logic [NUM_SLAVES-1:0]    i_s_int,
    input  logic [NUM_SLAVES-1:0]    i_int_en,
    output logic [NUM_SLAVES-1:0]    o_int_status,
    output logic [7:0]               o_err_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERROR  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic       TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    // Counter value seen in the last allowed ACTIVE cycle; unused when disabled.
    localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;
    localparam logic [8:0]  SLAVE_LIMIT  = 9'(NUM_SLAVES);

    state_t              state_reg, state_next;
    logic [3:0]          sel_reg, sel_next;
    logic [15:0]         cnt_reg, cnt_next;
    logic [31:0]         m_dat_reg, m_dat_next;
    logic                m_ack_reg, m_ack_next;
    logic                m_err_reg, m_err_next;
    logic                m_int_reg;
    logic [NUM_SLAVES-1:0] int_status_reg;
    logic [7:0]          err_count_reg;

    logic [NUM_SLAVES-1:0] hit;
    logic                  active;
    logic                  mapped;
    logic                  s_ack;
    logic [31:0]           s_rd_dat;
    logic [NUM_SLAVES-1:0] int_masked;

    assign active     = (state_reg == ACTIVE);
    assign mapped     = ({1'b0, i_m_adr[31:24]} < SLAVE_LIMIT);
    assign int_masked = i_s_int & i_int_en;

    // Per-slave fan-out. Only the latched slave sees the master's control
    // signals, and only while a transaction is being forwarded; address and
    // write data are quiet outside ACTIVE so idle slaves see a still bus.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
            assign hit[gi]              = (sel_reg == 4'(gi));
            assign o_s_stb[gi]          = active & hit[gi] & i_m_stb;
            assign o_s_cyc[gi]          = active & hit[gi] & i_m_cyc;
            assign o_s_we[gi]           = active & hit[gi] & i_m_we;
            assign o_s_sel[4*gi +: 4]   = (active && hit[gi]) ? i_m_sel : 4'h0;
            assign o_s_adr[32*gi +: 32] = active ? {8'h00, i_m_adr[23:0]} : 32'h0;
            assign o_s_dat[32*gi +: 32] = active ? i_m_dat : 32'h0;
        end
    endgenerate

    // Acks and read data from slaves other than the latched one are ignored.
    assign s_ack = |(i_s_ack & hit);

    always_comb begin
        s_rd_dat = 32'h0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (hit[i]) begin
                s_rd_dat = i_s_dat[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        cnt_next   = cnt_reg;
        m_dat_next = m_dat_reg;
        m_ack_next = 1'b0;
        m_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_m_cyc && i_m_stb) begin
                    if (mapped) begin
                        sel_next   = i_m_adr[27:24];
                        cnt_next   = 16'd0;
                        state_next = ACTIVE;
                    end else begin
                        state_next = ERROR;
                    end
                end
            end
            ACTIVE: begin
                if (!i_m_cyc) begin
                    // Master abandoned the cycle: no response is owed.
                    state_next = IDLE;
                end else if (s_ack) begin
                    // Ack is checked before the timeout so a coincident ack wins.
                    m_ack_next = 1'b1;
                    m_dat_next = s_rd_dat;
                    state_next = DONE;
                end else if (TIMEOUT_EN && (cnt_reg == TIMEOUT_LAST)) begin
                    m_err_next = 1'b1;
                    m_dat_next = 32'h0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ERROR: begin
                m_err_next = 1'b1;
                m_dat_next = 32'h0;
                state_next = DONE;
            end
            DONE: begin
                // Wait for the strobe to fall so one strobe gets one response.
                if (!i_m_stb) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            sel_reg        <= 4'h0;
            cnt_reg        <= 16'd0;
            m_dat_reg      <= 32'h0;
            m_ack_reg      <= 1'b0;
            m_err_reg      <= 1'b0;
            m_int_reg      <= 1'b0;
            int_status_reg <= '0;
            err_count_reg  <= 8'h00;
        end else begin
            state_reg      <= state_next;
            sel_reg        <= sel_next;
            cnt_reg        <= cnt_next;
            m_dat_reg      <= m_dat_next;
            m_ack_reg      <= m_ack_next;
            m_err_reg      <= m_err_next;
            m_int_reg      <= |int_masked;
            int_status_reg <= int_masked;
            if (m_err_next && (err_count_reg != 8'hFF)) begin
                err_count_reg <= err_count_reg + 8'h01;
            end
        end
    end

    assign o_m_dat      = m_dat_reg;
    assign o_m_ack      = m_ack_reg;
    assign o_m_err      = m_err_reg;
    assign o_m_int      = m_int_reg;
    assign o_int_status = int_status_reg;
    assign o_err_count  = err_count_reg;

endmodule
